// File: rtl/sevenseg_display_arbiter.sv
// Round-robin owner of the two-digit seven-segment path: holds each owner for
// HOLD_TICKS ticks and blanks the display for BLANK_CYCLES+1 cycles between owners.
module sevenseg_display_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int HOLD_TICKS   = 5,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tick,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*10-1:0]   req_data,
   output logic [NUM_REQ-1:0]      grant,
   output logic [1:0]              owner_id,
   output logic [9:0]              disp_data,
   output logic                    disp_load,
   output logic                    disp_enable
);

   localparam int HW = $clog2(HOLD_TICKS) + 1;
   localparam int BW = $clog2(BLANK_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

   state_t               state;
   logic [HW-1:0]        hold_cnt;
   logic [BW-1:0]        blank_cnt;
   logic [1:0]           rr_ptr;

   logic [9:0]           data_arr [NUM_REQ];
   logic                 sel_found;
   logic [1:0]           sel_idx;
   logic [1:0]           next_ptr;
   logic [NUM_REQ-1:0]   sel_onehot;
   logic                 owner_req;
   logic                 other_req;
   logic                 hold_last;
   logic [9:0]           owner_data;
   logic [9:0]           sel_data;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[10*g +: 10];
   end

   // First set request searching upward from rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = 2'd0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!sel_found && req[idx]) begin
            sel_found = 1'b1;
            sel_idx   = 2'(idx);
         end else begin
            sel_found = sel_found;
         end
      end
   end

   // Pointer after a grant, plus owner/contender status decoding.
   always_comb begin
      if (sel_idx == 2'(NUM_REQ - 1)) begin
         next_ptr = 2'd0;
      end else begin
         next_ptr = sel_idx + 2'd1;
      end
      sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
      owner_req  = |(req & grant);
      other_req  = |(req & ~grant);
      hold_last  = (hold_cnt == HW'(HOLD_TICKS - 1));
      owner_data = data_arr[owner_id];
      sel_data   = data_arr[sel_idx];
   end

   // Arbitration FSM; every output is a register written here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         owner_id    <= 2'd0;
         disp_data   <= 10'h000;
         disp_load   <= 1'b0;
         disp_enable <= 1'b0;
         hold_cnt    <= '0;
         blank_cnt   <= '0;
         rr_ptr      <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               disp_load <= 1'b0;
               if (sel_found) begin
                  grant       <= sel_onehot;
                  owner_id    <= sel_idx;
                  disp_data   <= sel_data;
                  disp_load   <= 1'b1;
                  disp_enable <= 1'b1;
                  hold_cnt    <= '0;
                  rr_ptr      <= next_ptr;
                  state       <= SHOW;
               end else begin
                  grant       <= '0;
                  disp_enable <= 1'b0;
               end
            end
            SHOW: begin
               disp_load <= 1'b0;
               // A dropped request wins over a coincident tick: no reload.
               if (!owner_req) begin
                  grant       <= '0;
                  disp_enable <= 1'b0;
                  blank_cnt   <= '0;
                  state       <= BLANK;
               end else if (tick) begin
                  if (hold_last && other_req) begin
                     grant       <= '0;
                     disp_enable <= 1'b0;
                     blank_cnt   <= '0;
                     state       <= BLANK;
                  end else if (hold_last) begin
                     disp_data <= owner_data;
                     disp_load <= 1'b1;
                     hold_cnt  <= '0;
                  end else begin
                     disp_data <= owner_data;
                     disp_load <= 1'b1;
                     hold_cnt  <= hold_cnt + HW'(1);
                  end
               end else begin
                  hold_cnt <= hold_cnt;
               end
            end
            BLANK: begin
               grant       <= '0;
               disp_enable <= 1'b0;
               disp_load   <= 1'b0;
               if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
                  state <= IDLE;
               end else begin
                  blank_cnt <= blank_cnt + BW'(1);
               end
            end
            default: begin
               state       <= IDLE;
               grant       <= '0;
               disp_load   <= 1'b0;
               disp_enable <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sevenseg_display_arbiter.md
Name: sevenseg_display_arbiter

Overview:
Shares the single two-digit seven-segment display path between up to four requesters, for example the BCD seconds counter, a status/error code source and a debug value. It grants the display round-robin and holds each owner for a fixed number of 1 Hz ticks. Between owners it blanks the display so that stale digits never appear. It sits between the requesters and the seven-segment decoder/driver, feeding that driver's data, buffer-load and enable inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..4.
- HOLD_TICKS, 5, ticks an owner keeps the display while others wait; must be >= 1.
- BLANK_CYCLES, 4, clk cycles with the display disabled between owners; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  single-cycle step strobe (1 Hz tick).
- req  input  NUM_REQ  per-requester level request; bit i belongs to requester i.
- req_data  input  NUM_REQ*10  requester i occupies bits [10*i+9:10*i]; format {dp_tens, dp_ones, tens[3:0], ones[3:0]}.
- grant  output  NUM_REQ  one-hot current owner; 0 when no owner.
- owner_id  output  2  index of the current or last owner.
- disp_data  output  10  data presented to the driver.
- disp_load  output  1  single-cycle strobe; the driver captures disp_data when it is high.
- disp_enable  output  1  driver enable; 0 blanks all segments.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, grant=0, owner_id=0, disp_data=10'h000, disp_load=0, disp_enable=0, hold_cnt=0, blank_cnt=0, rr_ptr=0.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - If req != 0, select the first set bit searching upward from rr_ptr with wrap.
  - Next edge: grant=onehot(w), owner_id=w, disp_data=req_data[w], disp_load=1, disp_enable=1, hold_cnt=0, rr_ptr=(w+1) mod NUM_REQ, state=SHOW.
  - Latency: req sampled at cycle n gives grant, load and enable visible at n+1.
  - If req == 0: stay in IDLE with disp_enable=0.
- SHOW:
  - disp_load defaults to 0.
  - On tick: disp_data=req_data[owner_id], disp_load=1 next cycle, hold_cnt increments.
  - Owner's req bit low: next edge grant=0, disp_enable=0, disp_load=0, blank_cnt=0, state=BLANK. This takes precedence over a simultaneous tick, and the data is not reloaded.
  - tick with hold_cnt==HOLD_TICKS-1 and another req bit set: go to BLANK as above. No reload on that tick.
  - tick with hold_cnt==HOLD_TICKS-1 and no other req bit set: reload data as a normal tick, hold_cnt=0, remain in SHOW (ownership renewed).
  - Requests from non-owners never pre-empt the owner before expiry.
- BLANK:
  - grant=0, disp_enable=0, disp_data holds its last value, tick is ignored.
  - blank_cnt increments each cycle; when blank_cnt==BLANK_CYCLES-1, next state is IDLE.
  - IDLE then arbitrates, so the display is dark for BLANK_CYCLES+1 cycles before the next owner.
- Round-robin: rr_ptr advances only on grant. A requester that just owned the display has the lowest priority at the next arbitration.
- hold_cnt width is clog2(HOLD_TICKS)+1 and it never exceeds HOLD_TICKS-1. blank_cnt width is clog2(BLANK_CYCLES)+1.
- rst asserted in any state, including mid-SHOW or mid-BLANK: all registers return to their reset values at the next edge, and no disp_load pulse is produced.
- req_data of non-owners is ignored. Owner data changes between ticks are not visible until the next tick.

Test Plan:
- Single owner:
  - Stimulus: rst released, req=0001 from cycle 2, req_data[9:0]=10'h012.
  - Required: cycle 3 shows grant=0001, owner_id=0, disp_data=10'h012, disp_load=1 for exactly one cycle, disp_enable=1.
  - With 12 further ticks: stays in SHOW, disp_load pulses on each tick, never blanks.
- Round-robin rotation:
  - Stimulus: req=1011 held, HOLD_TICKS=5.
  - Required: grant order 0001 -> 0010 -> 1000 -> 0001, each owner for exactly 5 ticks.
  - Between owners: disp_enable=0 for exactly 5 cycles (BLANK_CYCLES=4 plus the IDLE cycle).
- Early release:
  - Stimulus: owner 1 drops req after 2 ticks while req[2]=1.
  - Required: next edge grant=0, disp_enable=0; after blanking, grant=0100 and disp_data=req_data[2].
- Simultaneous drop and tick:
  - Stimulus: owner drops req in the same cycle as a tick.
  - Required: goes to BLANK; disp_load stays 0 and disp_data is unchanged.
- Expiry with no contender:
  - Stimulus: owner 0 alone, reaching hold_cnt=4 on a tick.
  - Required: disp_load=1, hold_cnt=0, grant stays 0001, disp_enable never drops.
- Reset mid-SHOW:
  - Stimulus: rst pulsed one cycle during SHOW.
  - Required: next cycle grant=0, disp_enable=0, disp_data=10'h000, disp_load=0.
  - After release with req=0110: requester 1 wins first, because rr_ptr was reset to 0.
